// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter between two byte requesters. A requester holds
// reqN high with its byte on dataN. While the arbiter is idle it grants one
// requester, latches that byte onto tx_data and pulses ackN for one cycle.
// It then holds tx_en high for FRAME_TICKS baud ticks, which covers start, data
// and stop bits. After that it waits GAP_TICKS idle baud ticks before it looks
// at requests again. When both requesters ask at once, the grant alternates.
//
// Parameters
//   FRAME_TICKS  baud ticks with tx_en high per byte (>= 2)
//   GAP_TICKS    idle baud ticks after each frame   (>= 1)
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   baud_tick    one-clk pulse per bit period
//   req0/req1    level requests
//   data0/data1  bytes offered, stable while the matching req is high
//   ack0/ack1    one-cycle pulse: the byte was latched
//   tx_en        enable to the shared transmitter
//   tx_data      byte presented to the transmitter
//   grant_id     index of the requester granted last
//   busy         high whenever the arbiter is not idle
// ----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int FRAME_TICKS = 10,
    parameter int GAP_TICKS   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic       ack0,
    output logic       ack1,
    output logic       tx_en,
    output logic [7:0] tx_data,
    output logic       grant_id,
    output logic       busy
);

    localparam int MAX_TICKS = (FRAME_TICKS > GAP_TICKS) ? FRAME_TICKS : GAP_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);

    // The counter runs 0 .. N-1. The tick that arrives at N-1 ends the
    // phase, so the counter never has to hold N and cannot wrap.
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_TICKS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]       state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic             tx_en_q,      tx_en_d;
    logic             ack0_q,       ack0_d;
    logic             ack1_q,       ack1_d;
    logic [7:0]       tx_data_q,    tx_data_d;
    logic             grant_id_q,   grant_id_d;
    logic             last_grant_q, last_grant_d;

    // Arbitration. On a tie the requester that did not win last time is
    // picked. Otherwise the single requester wins.
    logic grant_vld;
    logic grant_sel;

    always_comb begin
        grant_vld = req0 | req1;
        grant_sel = (req0 & req1) ? ~last_grant_q : req1;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tx_en_d      = tx_en_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        tx_data_d    = tx_data_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;

        unique case (state_q)
            ST_IDLE: begin
                // A baud_tick in the grant cycle is ignored on purpose.
                // Counting starts on the first tick after entry to SEND,
                // so the frame always covers FRAME_TICKS whole bit periods.
                if (grant_vld) begin
                    tx_data_d    = grant_sel ? data1 : data0;
                    ack0_d       = ~grant_sel;
                    ack1_d       = grant_sel;
                    grant_id_d   = grant_sel;
                    last_grant_d = grant_sel;
                    tx_en_d      = 1'b1;
                    cnt_d        = '0;
                    state_d      = ST_SEND;
                end
            end

            ST_SEND: begin
                if (baud_tick) begin
                    if (cnt_q == FRAME_LAST) begin
                        tx_en_d = 1'b0;
                        cnt_d   = '0;
                        state_d = ST_GAP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_GAP: begin
                if (baud_tick) begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                // Unreachable encoding. Go back to a safe idle state.
                tx_en_d = 1'b0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset has priority everywhere. A byte in flight is dropped without
    // any further ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            tx_en_q      <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            tx_data_q    <= 8'h00;
            grant_id_q   <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tx_en_q      <= tx_en_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            tx_data_q    <= tx_data_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign tx_en    = tx_en_q;
    assign tx_data  = tx_data_q;
    assign grant_id = grant_id_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter with its default parameters (10/1).
// A vector table covers grant selection and frame timing. Hand-written
// sequences cover late requests, withdrawn requests and reset mid-frame.
// ----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int FRAME_TICKS = 10;
    localparam int GAP_TICKS   = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_tick;
    logic       req0, req1;
    logic [7:0] data0, data1;
    logic       ack0, ack1;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       grant_id;
    logic       busy;

    int total_cnt = 0;
    int pass_cnt  = 0;

    uart_tx_arbiter #(.FRAME_TICKS(FRAME_TICKS), .GAP_TICKS(GAP_TICKS)) dut (
        .clk      (clk),
        .rst      (rst),
        .baud_tick(baud_tick),
        .req0     (req0),
        .req1     (req1),
        .data0    (data0),
        .data1    (data1),
        .ack0     (ack0),
        .ack1     (ack1),
        .tx_en    (tx_en),
        .tx_data  (tx_data),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r0, r1;
        logic [7:0] d0, d1;
        logic       coinc;   // baud_tick in the grant cycle
        logic       hold;    // keep reqs high through the frame
        logic       ea0, ea1;
        logic [7:0] edata;
        logic       egid;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Drives baud ticks with one idle clk between them. It counts ticks
    // until tx_en falls, then ticks until busy falls. It also checks that
    // tx_data and grant_id hold steady and that no ack fires meanwhile.
    task automatic run_frame(input logic [7:0] exp_data, input logic exp_gid,
                             output int nf, output int ng, output int bad);
        int guard;
        nf = 0; ng = 0; bad = 0; guard = 0;
        while (tx_en && guard < 100) begin
            baud_tick = 1'b1; step; baud_tick = 1'b0;
            nf++;
            if (tx_data !== exp_data || grant_id !== exp_gid || ack0 || ack1) bad++;
            if (tx_en) begin
                step;
                if (tx_data !== exp_data || grant_id !== exp_gid || ack0 || ack1) bad++;
            end
            guard++;
        end
        while (busy && guard < 100) begin
            baud_tick = 1'b1; step; baud_tick = 1'b0;
            ng++;
            if (tx_en || tx_data !== exp_data || grant_id !== exp_gid || ack0 || ack1) bad++;
            if (busy) step;
            guard++;
        end
    endtask

    initial begin
        int nf, ng, bad;

        // 1-4: tie after reset with both reqs held. The winner alternates.
        vecs[0] = '{1, 1, 8'h11, 8'h22, 0, 1, 1, 0, 8'h11, 0};
        vecs[1] = '{1, 1, 8'h11, 8'h22, 0, 1, 0, 1, 8'h22, 1};
        vecs[2] = '{1, 1, 8'h11, 8'h22, 0, 1, 1, 0, 8'h11, 0};
        vecs[3] = '{1, 1, 8'h11, 8'h22, 0, 0, 0, 1, 8'h22, 1};
        // 5: single req0 with a baud_tick in the grant cycle.
        vecs[4] = '{1, 0, 8'hA5, 8'h00, 1, 0, 1, 0, 8'hA5, 0};
        // 6: single req1.
        vecs[5] = '{0, 1, 8'h00, 8'h3C, 0, 0, 0, 1, 8'h3C, 1};
        // 7: tie after req1 won last, so req0 wins.
        vecs[6] = '{1, 1, 8'h5A, 8'hC3, 0, 0, 1, 0, 8'h5A, 0};

        rst = 1'b1; baud_tick = 1'b0; req0 = 1'b0; req1 = 1'b0;
        data0 = 8'h00; data1 = 8'h00;
        step; step;
        baud_tick = 1'b1; step; baud_tick = 1'b0;  // tick under reset: no effect
        rst = 1'b0;
        chk("rst_tx_en",    32'(tx_en),    32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_tx_data",  32'(tx_data),  32'h00);
        chk("rst_ack",      32'({ack0, ack1}), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);

        foreach (vecs[i]) begin
            req0 = vecs[i].r0; req1 = vecs[i].r1;
            data0 = vecs[i].d0; data1 = vecs[i].d1;
            baud_tick = vecs[i].coinc;
            step;
            baud_tick = 1'b0;
            chk($sformatf("v%0d_ack", i), 32'({ack0, ack1}), 32'({vecs[i].ea0, vecs[i].ea1}));
            chk($sformatf("v%0d_tx_data", i), 32'(tx_data), 32'(vecs[i].edata));
            chk($sformatf("v%0d_grant_id", i), 32'(grant_id), 32'(vecs[i].egid));
            chk($sformatf("v%0d_tx_en_busy", i), 32'({tx_en, busy}), 32'b11);
            if (!vecs[i].hold) begin req0 = 1'b0; req1 = 1'b0; end
            step;
            chk($sformatf("v%0d_ack_1cyc", i), 32'({ack0, ack1}), 32'd0);
            run_frame(vecs[i].edata, vecs[i].egid, nf, ng, bad);
            chk($sformatf("v%0d_frame_ticks", i), 32'(nf), 32'(FRAME_TICKS));
            chk($sformatf("v%0d_gap_ticks", i), 32'(ng), 32'(GAP_TICKS));
            chk($sformatf("v%0d_stable", i), 32'(bad), 32'd0);
            chk($sformatf("v%0d_idle_hold", i), 32'({tx_data, grant_id}), 32'({vecs[i].edata, vecs[i].egid}));
        end

        // Request raised mid-frame waits for IDLE.
        req0 = 1'b1; data0 = 8'h77; step; req0 = 1'b0;
        chk("late_ack0", 32'(ack0), 32'd1);
        for (int k = 0; k < 3; k++) begin
            baud_tick = 1'b1; step; baud_tick = 1'b0; step;
        end
        req1 = 1'b1; data1 = 8'h88;
        run_frame(8'h77, 1'b0, nf, ng, bad);
        chk("late_rest_ticks", 32'(nf), 32'(FRAME_TICKS - 3));
        chk("late_no_ack1_early", 32'(bad), 32'd0);
        step;
        chk("late_ack1", 32'({ack0, ack1}), 32'b01);
        chk("late_tx_data", 32'(tx_data), 32'h88);
        chk("late_grant_id", 32'(grant_id), 32'd1);
        req1 = 1'b0;
        step;
        run_frame(8'h88, 1'b1, nf, ng, bad);
        chk("late_frame_ticks", 32'(nf), 32'(FRAME_TICKS));

        // Request pulsed only while busy produces nothing.
        req0 = 1'b1; data0 = 8'h99; step; req0 = 1'b0;
        chk("wd_ack0", 32'(ack0), 32'd1);
        for (int k = 0; k < 2; k++) begin
            baud_tick = 1'b1; step; baud_tick = 1'b0; step;
        end
        req1 = 1'b1; data1 = 8'hEE; step; step; req1 = 1'b0;
        run_frame(8'h99, 1'b0, nf, ng, bad);
        chk("wd_frame_clean", 32'(bad), 32'd0);
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            baud_tick = k[0]; step; baud_tick = 1'b0;
            if (ack1 || busy || tx_en) bad++;
        end
        chk("wd_no_extra_frame", 32'(bad), 32'd0);
        chk("wd_tx_data_kept", 32'(tx_data), 32'h99);

        // Reset after the fourth SEND tick.
        req0 = 1'b1; data0 = 8'h44; step; req0 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            baud_tick = 1'b1; step; baud_tick = 1'b0; step;
        end
        chk("mid_tx_en_pre", 32'(tx_en), 32'd1);
        rst = 1'b1; step; rst = 1'b0;
        chk("mid_rst_tx_en",   32'(tx_en),   32'd0);
        chk("mid_rst_busy",    32'(busy),    32'd0);
        chk("mid_rst_tx_data", 32'(tx_data), 32'h00);
        chk("mid_rst_ack",     32'({ack0, ack1}), 32'd0);
        chk("mid_rst_gid",     32'(grant_id), 32'd0);
        req1 = 1'b1; data1 = 8'hE7; step; req1 = 1'b0;
        chk("post_rst_ack1",    32'({ack0, ack1}), 32'b01);
        chk("post_rst_tx_data", 32'(tx_data), 32'hE7);
        step;
        run_frame(8'hE7, 1'b1, nf, ng, bad);
        chk("post_rst_frame_ticks", 32'(nf), 32'(FRAME_TICKS));
        chk("post_rst_gap_ticks",   32'(ng), 32'(GAP_TICKS));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter FRAME_TICKS, default 10, SHALL set the number of baud ticks tx_en is held high per byte (start + 8 data + stop); legal range >= 2.
REQ-002 Parameter GAP_TICKS, default 1, SHALL set the number of idle baud ticks after each frame; legal range >= 1.
REQ-003 clk  input  1  SHALL be the single system clock; all logic is on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 baud_tick  input  1  SHALL be a one-clk-cycle pulse per bit period, synchronous to clk.
REQ-006 req0, req1  input  1 each  SHALL be level request from requester 0 and requester 1.
REQ-007 data0, data1  input  8 each  SHALL be the byte offered by requester 0 and requester 1, stable while the matching req is high.
REQ-008 ack0, ack1  output  1 each  SHALL be a one-cycle pulse meaning the byte was latched.
REQ-009 tx_en  output  1  SHALL be the enable to the shared UART transmitter.
REQ-010 tx_data  output  8  SHALL be the byte presented to the shared transmitter.
REQ-011 grant_id  output  1  SHALL be the index of the requester last granted.
REQ-012 busy  output  1  SHALL be high whenever state != IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SEND, GAP.
REQ-014 In IDLE, req0/req1 SHALL be sampled every clk; with no req high the FSM SHALL stay in IDLE.
REQ-015 Single req high in IDLE: that requester SHALL be granted.
REQ-016 Both req high in IDLE: the requester != last_grant SHALL win (round-robin); last_grant resets to 1, so req0 wins the first tie.
REQ-017 On grant edge: tx_data <= dataN, ackN <= 1, grant_id <= N, last_grant <= N, tx_en <= 1, tick counter <= 0, state <= SEND.
REQ-018 ack SHALL appear exactly 1 clk after the sampling edge, last exactly one cycle, and never be high for both requesters at once.
REQ-019 In SEND, each baud_tick SHALL increment the counter; the baud_tick of the final count (FRAME_TICKS-th tick) SHALL clear tx_en, zero the counter and move to GAP.
REQ-020 A baud_tick coincident with the grant edge SHALL NOT be counted; counting starts the cycle after entry to SEND.
REQ-021 In GAP, tx_en SHALL stay 0; on the GAP_TICKS-th baud_tick the FSM SHALL return to IDLE.
REQ-022 tx_data and grant_id SHALL hold stable from grant through the end of GAP, and SHALL retain value in IDLE.
REQ-023 req changes outside IDLE SHALL be ignored; a req dropped before its ack SHALL produce no transfer.
REQ-024 A req still high after its ack SHALL be treated as a new request at the next IDLE (requesters deassert on ack).
REQ-025 Minimum spacing between consecutive grants SHALL be FRAME_TICKS + GAP_TICKS baud ticks plus 1 clk.
REQ-026 Tick counter width SHALL be clog2(max(FRAME_TICKS, GAP_TICKS)+1) bits; it SHALL never wrap.

Reset
REQ-027 When rst is high at a clk edge: state <= IDLE, tx_en <= 0, ack0 <= 0, ack1 <= 0, tx_data <= 8'h00, grant_id <= 0, last_grant <= 1, counter <= 0; busy goes 0.
REQ-028 Reset SHALL take priority over all other inputs, including mid-SEND or mid-GAP; the in-flight byte is abandoned without a second ack.
REQ-029 Cycle after rst deasserts, the FSM SHALL accept requests normally.

Verification
REQ-030 Single request: req0=1, data0=8'hA5 in IDLE -> ack0 one cycle later, tx_data=8'hA5, tx_en high for exactly 10 baud_ticks, low for 1, then busy=0.
REQ-031 Tie after reset: req0=req1=1, data0=8'h11, data1=8'h22, both held -> grants alternate 11,22,11,22; grant_id toggles 0,1,0,1.
REQ-032 Request during frame: req1 raised mid-SEND of req0's byte -> no ack1 until IDLE, then ack1 and tx_data=data1.
REQ-033 Withdrawn request: req1 pulsed high only while busy=1 -> no ack1, no extra frame.
REQ-034 Reset mid-frame: rst high after tick 4 of SEND -> next edge tx_en=0, busy=0, tx_data=8'h00, no ack; a request afterwards completes a full 10-tick frame.
REQ-035 Coincident tick: baud_tick in the grant cycle -> not counted; tx_en still spans 10 subsequent ticks.
